pdm_tx_modulator: RTL and testbench
===================================

PDM_TX_MODULATOR -- requirements
Module: pdm_tx_modulator

Interface
REQ-001 Parameter DATA_W, default 16, signed PCM sample width.
REQ-002 Parameter OSR, default 64, PDM bits emitted per PCM sample; power of two, 2..256.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 enable  input  1  soft enable; low flushes the block to idle.
REQ-006 m_clk_rising  input  1  one-clk strobe per PDM bit period, from the PDM clock generator.
REQ-007 s_axis_tdata  input  DATA_W  signed two's-complement PCM sample.
REQ-008 s_axis_tvalid  input  1  sample valid.
REQ-009 s_axis_tready  output  1  block can accept a sample.
REQ-010 pdm_data  output  1  registered PDM bit to the off-chip PDM device.
REQ-011 underrun  output  1  one-clk pulse when a sample period ends with no sample buffered.
REQ-012 underrun_cnt  output  16  saturating underrun count; present only with PDM_TX_UNDERRUN_CNT_EN.

Function
REQ-013 Storage: cur register (sample being modulated) plus one-deep next buffer with next_valid flag.
REQ-014 s_axis_tready SHALL equal enable AND NOT next_valid, registered, with no combinational path from tvalid.
REQ-015 Transfer on tvalid AND tready loads next and sets next_valid; consumption clears next_valid; tready rises the cycle after consumption.
REQ-016 Modulator: u = tdata with MSB inverted (offset binary); on each active strobe {carry, acc} = acc + u (DATA_W+1 bits); pdm_data <= carry.
REQ-017 pdm_data SHALL update exactly 1 clk after the m_clk_rising strobe and hold until the next strobe.
REQ-018 Bit counter, width log2(OSR), increments per strobe in RUN and wraps from OSR-1 to 0.
REQ-019 State IDLE: modulates u = 2^(DATA_W-1) (zero code); bit counter held at 0; IDLE -> RUN on a strobe with next_valid=1, loading cur from next.
REQ-020 State RUN: at a strobe with count = OSR-1, load cur from next if next_valid; otherwise pulse underrun, load zero code, and go to IDLE.
REQ-021 The new cur applies from the strobe after the load; the wrap strobe still modulates the old cur.
REQ-022 A sample accepted in the same cycle as a wrap strobe with next_valid=0 SHALL NOT prevent the underrun; it is used on the IDLE -> RUN strobe.
REQ-023 enable low: state IDLE, acc=0, next_valid=0, bit counter=0, pdm_data=0, tready=0; strobes ignored.
REQ-024 Strobes with rst high or enable low SHALL produce no underrun.

Reset
REQ-025 rst SHALL asynchronously force state IDLE, acc=0, cur=zero code, next_valid=0, counter=0, pdm_data=0, s_axis_tready=0, underrun=0, underrun_cnt=0.
REQ-026 tready SHALL rise no earlier than the second clk after rst deasserts, with enable high.
REQ-027 Reset mid-sample SHALL discard cur and next; no partial sample resumes.

Configuration
REQ-028 With PDM_TX_UNDERRUN_CNT_EN defined, underrun_cnt increments on each underrun pulse and saturates at 0xFFFF; cleared by rst only.
REQ-029 Without PDM_TX_UNDERRUN_CNT_EN, the underrun_cnt port and counter SHALL be absent; underrun pulse is unaffected.

Verification
REQ-030 Idle after reset, enable=1, strobes every 40 clk, no samples -> pdm_data 0,1,0,1 repeating; no underrun.
REQ-031 Stream 0x7FFF continuously, OSR=64 -> 64 bits of 65535/65536 density: exactly one 0 in the first 65536 bits; no underrun; tready never stuck.
REQ-032 Stream 0x8000 -> pdm_data constant 0 after the IDLE -> RUN strobe; 0x4000 -> '1' density 0.75 (48 of 64 bits).
REQ-033 One sample 0x0000 then stop -> after 64 strobes: underrun pulses once, state IDLE, zero pattern resumes; underrun_cnt=1 if the macro is defined.
REQ-034 tvalid held high, strobes active -> exactly one transfer per 64 strobes in steady state; tready high only while next is empty.
REQ-035 rst asserted mid-sample at count 17 -> pdm_data=0 and tready=0 asynchronously; after release, the first output follows the REQ-030 pattern.

Source files
------------

// File: rtl/pdm_tx_modulator.sv
// rtl/pdm_tx_modulator.sv - first-order sigma-delta PCM-to-PDM transmitter with one-deep sample buffer
// Optional saturating underrun counter port: define PDM_TX_UNDERRUN_CNT_EN.
module pdm_tx_modulator #(
    parameter int DATA_W = 16,
    parameter int OSR    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              m_clk_rising,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic              pdm_data,
    output logic              underrun
`ifdef PDM_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int CNT_W = $clog2(OSR);
    localparam logic [DATA_W-1:0] ZERO_CODE = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] r_next;
    logic              r_next_valid;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pdm;
    logic              r_tready;
    logic              r_underrun;
    logic              r_boot;

    logic              w_strobe;
    logic              w_xfer;
    logic              w_wrap;
    logic              w_load;
    logic              w_under;
    logic              w_next_valid_d;
    logic [DATA_W:0]   w_sum;

    // Samples are held in offset binary so the accumulator add is unsigned.
    assign w_strobe       = enable & m_clk_rising;
    assign w_xfer         = s_axis_tvalid & r_tready;
    assign w_sum          = {1'b0, r_acc} + {1'b0, r_cur};
    assign w_wrap         = (r_state == ST_RUN) && (r_cnt == CNT_W'(OSR - 1));
    assign w_load         = w_strobe & r_next_valid & ((r_state == ST_IDLE) | w_wrap);
    assign w_under        = w_strobe & ~r_next_valid & w_wrap;
    assign w_next_valid_d = w_xfer | (r_next_valid & ~w_load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_cur        <= ZERO_CODE;
            r_next       <= ZERO_CODE;
            r_next_valid <= 1'b0;
            r_cnt        <= '0;
            r_pdm        <= 1'b0;
            r_tready     <= 1'b0;
            r_underrun   <= 1'b0;
            r_boot       <= 1'b0;
        end else begin
            r_boot     <= 1'b1;
            r_underrun <= 1'b0;
            if (!enable) begin
                r_state      <= ST_IDLE;
                r_acc        <= '0;
                r_cur        <= ZERO_CODE;
                r_next_valid <= 1'b0;
                r_cnt        <= '0;
                r_pdm        <= 1'b0;
                r_tready     <= 1'b0;
            end else begin
                if (w_xfer) begin
                    r_next <= s_axis_tdata ^ ZERO_CODE;
                end
                r_next_valid <= w_next_valid_d;
                // r_boot keeps tready low for the first clk after reset release.
                r_tready     <= r_boot & ~w_next_valid_d;
                if (w_strobe) begin
                    r_acc <= w_sum[DATA_W-1:0];
                    r_pdm <= w_sum[DATA_W];
                    if (r_state == ST_RUN) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_load) begin
                        r_cur   <= r_next;
                        r_state <= ST_RUN;
                    end else if (w_under) begin
                        r_cur      <= ZERO_CODE;
                        r_state    <= ST_IDLE;
                        r_underrun <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef PDM_TX_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun_cnt <= '0;
        end else if (w_under && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

    assign s_axis_tready = r_tready;
    assign pdm_data      = r_pdm;
    assign underrun      = r_underrun;

endmodule

// File: tb/tb_pdm_tx_modulator.sv
// tb/tb_pdm_tx_modulator.sv - scoreboard bench for pdm_tx_modulator against a per-strobe sigma-delta model
`timescale 1ns/1ps
module tb_pdm_tx_modulator;

    localparam int DATA_W = 16;
    localparam int OSR    = 64;
    localparam int FULL   = 1 << DATA_W;
    localparam int ZERO_U = 1 << (DATA_W - 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              m_clk_rising = 1'b0;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic              pdm_data;
    logic              underrun;
`ifdef PDM_TX_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pdm_tx_modulator #(.DATA_W(DATA_W), .OSR(OSR)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .m_clk_rising  (m_clk_rising),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .pdm_data      (pdm_data),
        .underrun      (underrun)
`ifdef PDM_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt  (underrun_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per observed strobe; whole-sample bookkeeping.
    bit m_run, m_nv, m_tready, m_boot, m_pdm, m_strobed;
    int m_pos, m_cur, m_next, m_acc, m_ucnt, n_xfers;
    int exp_q[$];
    int md_sum;
    bit md_strobe, md_xfer, md_und, md_bit;

    function automatic void model_reset();
        m_run = 0; m_nv = 0; m_tready = 0; m_boot = 0; m_pdm = 0; m_strobed = 0;
        m_pos = 0; m_cur = ZERO_U; m_next = ZERO_U; m_acc = 0; m_ucnt = 0;
        exp_q.delete();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            md_strobe = m_clk_rising && enable;
            md_xfer   = s_axis_tvalid && m_tready && enable;
            m_strobed = md_strobe;
            if (!enable) begin
                m_run = 0; m_pos = 0; m_acc = 0; m_cur = ZERO_U;
                m_nv = 0; m_pdm = 0; m_tready = 0;
            end else begin
                if (md_strobe) begin
                    md_sum = m_acc + m_cur;
                    md_bit = (md_sum >= FULL);
                    m_acc  = md_sum % FULL;
                    md_und = 0;
                    if (!m_run) begin
                        if (m_nv) begin
                            m_cur = m_next; m_nv = 0; m_run = 1; m_pos = 0;
                        end
                    end else begin
                        if (m_pos == OSR - 1) begin
                            if (m_nv) begin
                                m_cur = m_next; m_nv = 0;
                            end else begin
                                md_und = 1; m_cur = ZERO_U; m_run = 0;
                            end
                        end
                        m_pos = (m_pos + 1) % OSR;
                    end
                    m_pdm = md_bit;
                    if (md_und && m_ucnt < 65535) m_ucnt++;
                    exp_q.push_back(int'(md_und) * 2 + int'(md_bit));
                end
                if (md_xfer) begin
                    m_next = int'(s_axis_tdata) ^ ZERO_U;
                    m_nv   = 1;
                    n_xfers++;
                end
                m_tready = m_boot && !m_nv;
            end
            m_boot = 1;
        end
    end

    // Monitor: pops one expectation per strobe, checks hold/pulse otherwise.
    int  mon_e;
    int  und_seen = 0;
    bit  dens_active = 0;
    int  dens_n = 0;
    int  dens_ones = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_strobed) begin
                if (exp_q.size() == 0) begin
                    chk("queue_empty", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pdm_bit", int'(pdm_data), mon_e % 2);
                    chk("underrun_pulse", int'(underrun), mon_e / 2);
                    if (dens_active && dens_n < OSR) begin
                        dens_n++;
                        dens_ones += int'(pdm_data);
                    end
                end
            end else begin
                chk("pdm_hold", int'(pdm_data), int'(m_pdm));
                chk("underrun_idle", int'(underrun), 0);
            end
            chk("tready", int'(s_axis_tready), int'(m_tready));
            if (underrun) und_seen++;
        end
    end

    int strobe_per = 40;
    int strobe_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            strobe_cnt++;
            if (strobe_cnt >= strobe_per) begin
                strobe_cnt   = 0;
                m_clk_rising = 1'b1;
            end else begin
                m_clk_rising = 1'b0;
            end
        end
    end

    task automatic measure_density(output int ones);
        dens_n = 0; dens_ones = 0; dens_active = 1;
        for (int i = 0; i < 2000 && dens_n < OSR; i++) @(negedge clk);
        dens_active = 0;
        chk("density_window_done", dens_n, OSR);
        ones = dens_ones;
    endtask

    int ones, base_und, base_x, pct;

    initial begin
        model_reset();
        n_xfers = 0;
        repeat (3) @(negedge clk);
        chk("rst_pdm", int'(pdm_data), 0);
        chk("rst_tready", int'(s_axis_tready), 0);
        chk("rst_underrun", int'(underrun), 0);
`ifdef PDM_TX_UNDERRUN_CNT_EN
        chk("rst_underrun_cnt", int'(underrun_cnt), 0);
`endif
        rst = 1'b0; enable = 1'b1;
        @(negedge clk);
        chk("tready_first_clk", int'(s_axis_tready), 0);

        // Idle zero pattern with slow strobes.
        repeat (400) @(negedge clk);
        chk("idle_no_underrun", und_seen, 0);

        // Continuous streams: density checks and one transfer per sample period.
        strobe_per = 2;
        s_axis_tdata = 16'h4000; s_axis_tvalid = 1'b1;
        repeat (300) @(negedge clk);
        measure_density(ones);
        chk("density_4000", ones, 48);
        base_x = n_xfers;
        repeat (OSR * 2 * 4) @(negedge clk);
        chk("xfer_rate", n_xfers - base_x, 4);
        s_axis_tdata = 16'h8000;
        repeat (400) @(negedge clk);
        measure_density(ones);
        chk("density_8000", ones, 0);
        s_axis_tdata = 16'h7FFF;
        repeat (400) @(negedge clk);
        measure_density(ones);
        chk("density_7fff", int'(ones >= 63), 1);
        chk("stream_no_underrun", und_seen, 0);

        // Stop the stream, flush, then a single zero sample must end in one underrun.
        s_axis_tvalid = 1'b0;
        repeat (400) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("disabled_pdm", int'(pdm_data), 0);
        enable = 1'b1;
        for (int i = 0; i < 50 && !s_axis_tready; i++) @(negedge clk);
        chk("single_tready", int'(s_axis_tready), 1);
        base_und = und_seen;
        s_axis_tdata = 16'h0000; s_axis_tvalid = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        repeat (OSR * 2 + 40) @(negedge clk);
        chk("single_underrun_once", und_seen - base_und, 1);
        chk("single_back_idle", int'(m_run), 0);

        // Randomized traffic, strobe rates and enable drops.
        for (int blk = 0; blk < 40; blk++) begin
            strobe_per = $urandom_range(1, 4);
            case ($urandom_range(0, 3))
                0: pct = 1;
                1: pct = 2;
                2: pct = 10;
                default: pct = 60;
            endcase
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                s_axis_tvalid = ($urandom_range(0, 99) < pct);
                s_axis_tdata  = DATA_W'($urandom);
                if ($urandom_range(0, 1999) == 0) enable = 1'b0;
                else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            end
        end
        enable = 1'b1;

        // Asynchronous reset in the middle of a sample.
        strobe_per = 3;
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'h3A5C;
        for (int i = 0; i < 2000 && !(m_run && m_pos == 17); i++) @(negedge clk);
        chk("reached_count17", int'(m_run && m_pos == 17), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pdm", int'(pdm_data), 0);
        chk("async_rst_tready", int'(s_axis_tready), 0);
        chk("async_rst_underrun", int'(underrun), 0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        rst = 1'b0;
        base_und = und_seen;
        repeat (OSR * 3 * 2) @(negedge clk);
        chk("post_rst_no_underrun", und_seen - base_und, 0);
`ifdef PDM_TX_UNDERRUN_CNT_EN
        chk("underrun_cnt", int'(underrun_cnt), m_ucnt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
